// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the N-master bus arbiter and its picker.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    SNREADY = 2'd2
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/arb_picker.sv
// Combinational request picker: fixed priority (lowest index) or round-robin
// search from rr_ptr, with an optional mask that is ignored if it hides every request.
module arb_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int SEL_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] mask,
  input  logic [SEL_W-1:0]       rr_ptr,
  input  logic                   mode,
  output logic                   valid,
  output logic [SEL_W-1:0]       index
);

  logic [NUM_MASTERS-1:0] cand;
  logic [SEL_W-1:0]       idx;
  int                     start;
  int                     j;

  always_comb begin
    cand  = req & ~mask;
    if (cand == '0) cand = req;
    valid = 1'b0;
    index = '0;
    idx   = '0;
    j     = 0;
    start = mode ? int'(rr_ptr) : 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      j = start + k;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      idx = SEL_W'(j);
      if (!valid && cand[idx]) begin
        valid = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-master system bus arbiter: fixed-priority or round-robin, optional hold
// limit with preemption, and re-arbitration only once all slaves report ready.
module bus_arbiter_n
  import bus_arb_pkg::*;
#(
  parameter  int NUM_MASTERS = 4,
  parameter  int NUM_SLAVES  = 3,
  parameter  int ARB_MODE    = 0,
  parameter  int MAX_HOLD    = 0,
  localparam int SEL_W       = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] breq,
  input  logic [NUM_SLAVES-1:0]  sready,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [SEL_W-1:0]       msel,
  output logic                   bus_busy
);

  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       owner_q, owner_d;
  logic [SEL_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [NUM_MASTERS-1:0] preempt_mask_q, preempt_mask_d;

  logic                   pick_valid;
  logic [SEL_W-1:0]       pick_idx;
  logic [SEL_W-1:0]       ptr_on_grant;
  logic                   others_req;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot = NUM_MASTERS'(1) << i;
  endfunction

  arb_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .SEL_W       (SEL_W)
  ) u_picker (
    .req    (breq),
    .mask   (preempt_mask_q),
    .rr_ptr (rr_ptr_q),
    .mode   (ARB_MODE == ARB_RR),
    .valid  (pick_valid),
    .index  (pick_idx)
  );

  // Round-robin resumes the search just past the newly granted master.
  always_comb begin
    ptr_on_grant = '0;
    if (ARB_MODE == ARB_RR) begin
      ptr_on_grant = (pick_idx == SEL_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  assign others_req = |(breq & ~onehot(owner_q));

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    hold_cnt_d     = hold_cnt_q;
    preempt_mask_d = preempt_mask_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = GRANT;
          owner_d    = pick_idx;
          hold_cnt_d = '0;
          rr_ptr_d   = ptr_on_grant;
        end
      end
      GRANT: begin
        if (!breq[owner_q]) begin
          state_d        = SNREADY;
          preempt_mask_d = '0;
        end else if (MAX_HOLD != 0 && hold_cnt_q == HOLD_LAST && others_req) begin
          state_d        = SNREADY;
          preempt_mask_d = onehot(owner_q);
        end else if (others_req) begin
          hold_cnt_d = (hold_cnt_q < HOLD_LAST) ? hold_cnt_q + 1'b1 : hold_cnt_q;
        end else begin
          hold_cnt_d = '0;
        end
      end
      SNREADY: begin
        if (&sready) begin
          preempt_mask_d = '0;
          if (pick_valid) begin
            state_d    = GRANT;
            owner_d    = pick_idx;
            hold_cnt_d = '0;
            rr_ptr_d   = ptr_on_grant;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      owner_q        <= '0;
      rr_ptr_q       <= '0;
      hold_cnt_q     <= '0;
      preempt_mask_q <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      rr_ptr_q       <= rr_ptr_d;
      hold_cnt_q     <= hold_cnt_d;
      preempt_mask_q <= preempt_mask_d;
    end
  end

  assign bgrant   = (state_q == GRANT) ? onehot(owner_q) : '0;
  assign msel     = owner_q;
  assign bus_busy = (state_q != IDLE);

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Directed bench for bus_arbiter_n: four instances cover fixed/RR modes with
// and without a hold limit; expected values are hand-derived per step.
module tb_bus_arbiter_n;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] sready;

  logic [3:0] breq_fx, breq_rr, breq_rrh, breq_fxh;
  logic [3:0] gnt_fx, gnt_rr, gnt_rrh, gnt_fxh;
  logic [1:0] sel_fx, sel_rr, sel_rrh, sel_fxh;
  logic       busy_fx, busy_rr, busy_rrh, busy_fxh;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter_n #(.NUM_MASTERS(4), .NUM_SLAVES(3), .ARB_MODE(0), .MAX_HOLD(0)) u_fx (
    .clk(clk), .rstn(rstn), .breq(breq_fx), .sready(sready),
    .bgrant(gnt_fx), .msel(sel_fx), .bus_busy(busy_fx));

  bus_arbiter_n #(.NUM_MASTERS(4), .NUM_SLAVES(3), .ARB_MODE(1), .MAX_HOLD(0)) u_rr (
    .clk(clk), .rstn(rstn), .breq(breq_rr), .sready(sready),
    .bgrant(gnt_rr), .msel(sel_rr), .bus_busy(busy_rr));

  bus_arbiter_n #(.NUM_MASTERS(4), .NUM_SLAVES(3), .ARB_MODE(1), .MAX_HOLD(4)) u_rrh (
    .clk(clk), .rstn(rstn), .breq(breq_rrh), .sready(sready),
    .bgrant(gnt_rrh), .msel(sel_rrh), .bus_busy(busy_rrh));

  bus_arbiter_n #(.NUM_MASTERS(4), .NUM_SLAVES(3), .ARB_MODE(0), .MAX_HOLD(4)) u_fxh (
    .clk(clk), .rstn(rstn), .breq(breq_fxh), .sready(sready),
    .bgrant(gnt_fxh), .msel(sel_fxh), .bus_busy(busy_fxh));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn     = 1'b0;
    sready   = 3'b111;
    breq_fx  = '0;
    breq_rr  = '0;
    breq_rrh = '0;
    breq_fxh = '0;
    #1;
    check("rst_gnt",  32'(gnt_fx),  32'h0);
    check("rst_sel",  32'(sel_fx),  32'h0);
    check("rst_busy", 32'(busy_fx), 32'h0);
    check("rst_rr_busy", 32'(busy_rr), 32'h0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    check("idle_busy", 32'(busy_fx), 32'h0);

    // Fixed priority: lowest index wins, slaves must all be ready to re-arbitrate
    breq_fx = 4'b1010;
    tick();
    check("fx_gnt1", 32'(gnt_fx),  32'h2);
    check("fx_sel1", 32'(sel_fx),  32'h1);
    check("fx_busy", 32'(busy_fx), 32'h1);
    breq_fx = 4'b1000;
    sready  = 3'b011;
    tick();
    check("fx_sn_gnt",  32'(gnt_fx),  32'h0);
    check("fx_sn_busy", 32'(busy_fx), 32'h1);
    check("fx_sn_sel",  32'(sel_fx),  32'h1);
    tick();
    check("fx_sn_wait", 32'(gnt_fx), 32'h0);
    sready = 3'b111;
    tick();
    check("fx_gnt3", 32'(gnt_fx), 32'h8);
    check("fx_sel3", 32'(sel_fx), 32'h3);
    breq_fx = 4'b0000;
    tick();
    check("fx_rel_gnt", 32'(gnt_fx), 32'h0);
    tick();
    check("fx_idle_busy", 32'(busy_fx), 32'h0);
    check("fx_idle_sel",  32'(sel_fx),  32'h3);
    check("fx_idle_gnt",  32'(gnt_fx),  32'h0);

    // Round-robin rotation with all masters requesting
    breq_rr = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_gnt_a", 32'(gnt_rr), 32'(4'b0001 << (i % 4)));
      check("rr_sel",   32'(sel_rr), 32'(i % 4));
      tick();
      check("rr_gnt_b", 32'(gnt_rr), 32'(4'b0001 << (i % 4)));
      breq_rr = 4'b1111 & ~(4'b0001 << (i % 4));
      tick();
      check("rr_sn_gnt", 32'(gnt_rr), 32'h0);
      breq_rr = 4'b1111;
    end
    breq_rr = 4'b0000;
    tick();
    check("rr_idle_busy", 32'(busy_rr), 32'h0);

    // Round-robin with hold limit: master 2 preempted in favour of master 0
    breq_rrh = 4'b0100;
    tick();
    check("rrh_gnt2", 32'(gnt_rrh), 32'h4);
    breq_rrh = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rrh_hold", 32'(gnt_rrh), 32'h4);
    end
    tick();
    check("rrh_preempt_gnt",  32'(gnt_rrh),  32'h0);
    check("rrh_preempt_busy", 32'(busy_rrh), 32'h1);
    tick();
    check("rrh_gnt0", 32'(gnt_rrh), 32'h1);
    check("rrh_sel0", 32'(sel_rrh), 32'h0);
    breq_rrh = 4'b0100;
    tick();
    check("rrh_rel", 32'(gnt_rrh), 32'h0);
    tick();
    check("rrh_gnt2_again", 32'(gnt_rrh), 32'h4);
    breq_rrh = 4'b0000;
    tick();
    tick();
    check("rrh_idle", 32'(busy_rrh), 32'h0);

    // Fixed priority with hold limit: master 0 yields once to master 3
    breq_fxh = 4'b0001;
    tick();
    check("fxh_gnt0", 32'(gnt_fxh), 32'h1);
    breq_fxh = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fxh_hold", 32'(gnt_fxh), 32'h1);
    end
    tick();
    check("fxh_preempt", 32'(gnt_fxh), 32'h0);
    tick();
    check("fxh_gnt3", 32'(gnt_fxh), 32'h8);
    check("fxh_sel3", 32'(sel_fxh), 32'h3);
    breq_fxh = 4'b0001;
    tick();
    check("fxh_rel", 32'(gnt_fxh), 32'h0);
    tick();
    check("fxh_gnt0_again", 32'(gnt_fxh), 32'h1);
    breq_fxh = 4'b0000;
    tick();
    tick();
    check("fxh_idle", 32'(busy_fxh), 32'h0);

    // Asynchronous reset between clock edges drops the grant immediately
    breq_fx = 4'b0100;
    tick();
    check("ar_pre_gnt", 32'(gnt_fx), 32'h4);
    check("ar_pre_sel", 32'(sel_fx), 32'h2);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_gnt",  32'(gnt_fx),  32'h0);
    check("ar_busy", 32'(busy_fx), 32'h0);
    check("ar_sel",  32'(sel_fx),  32'h0);
    breq_fx = 4'b0000;
    tick();
    rstn = 1'b1;
    tick();
    tick();
    check("ar_post_busy", 32'(busy_fx), 32'h0);
    check("ar_post_gnt",  32'(gnt_fx),  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_n.md
Name: bus_arbiter_n

Overview:
Parametrised bus arbiter for the system bus. It serves NUM_MASTERS requesters and offers fixed-priority or round-robin arbitration. An optional hold-limit preempts a master that keeps the bus while others wait. Like the existing two-master arbiter, it sits between master request lines and the master-select mux, and it waits for all slaves to report ready before it re-arbitrates.

Parameters:
NUM_MASTERS, 4, number of requesting masters (>= 2).
NUM_SLAVES, 3, number of slave ready inputs, ANDed together.
ARB_MODE, 0, 0 = fixed priority (index 0 highest), 1 = round-robin.
MAX_HOLD, 0, maximum consecutive grant cycles while another master requests; 0 = unlimited.
SEL_W, $clog2(NUM_MASTERS), derived localparam: msel width.

Ports:
clk  in  1  system clock, rising edge.
rstn  in  1  asynchronous active-low reset.
breq  in  NUM_MASTERS  bus request, bit i from master i, level-held while bus needed.
sready  in  NUM_SLAVES  slave ready, bit j from slave j.
bgrant  out  NUM_MASTERS  one-hot grant; all zero when no grant.
msel  out  SEL_W  index of current/last owner, drives master mux.
bus_busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, owner=0, rr_ptr=0, hold_cnt=0, preempt_mask=0.
  - bgrant=0, msel=0, bus_busy=0, immediately and irrespective of clk.
  - Reset mid-transfer drops the grant at once; no completion is owed.
- States:
  - IDLE: no owner.
  - GRANT: owner holds the bus.
  - SNREADY: master released, waiting for slaves.
- Arbitration function, pick(req): candidates = req & ~preempt_mask.
  - Fixed mode: lowest set index wins.
  - RR mode: first set index found searching upward from rr_ptr, wrapping at NUM_MASTERS-1 -> 0.
  - If candidates=0 but req!=0, arbitrate over req unmasked.
  - Returns valid and index.
- IDLE: if pick(breq) is valid -> GRANT, owner<=index; otherwise stay in IDLE.
- GRANT:
  - If breq[owner]=0 -> SNREADY; preempt_mask<=0.
  - Else if MAX_HOLD!=0, hold_cnt==MAX_HOLD-1 and another breq bit is set -> SNREADY; preempt_mask<=onehot(owner).
  - Otherwise stay in GRANT. hold_cnt increments, saturating at MAX_HOLD-1, and only while another master requests; it is 0 otherwise.
- SNREADY:
  - Wait until &sready=1.
  - Then: if pick(breq) is valid -> GRANT with the new owner; otherwise -> IDLE.
  - preempt_mask clears on leaving SNREADY.
- Every entry to GRANT: hold_cnt<=0.
  - RR mode: rr_ptr<=(index+1) mod NUM_MASTERS.
  - Fixed mode: rr_ptr is unused and stays 0.
- Outputs (Moore, decoded from registers):
  - bgrant = onehot(owner) in GRANT, else 0.
  - msel = owner; retains the last owner outside GRANT.
  - bus_busy = (state != IDLE).
- Latency:
  - Request in IDLE -> grant visible the next cycle.
  - Release -> at least 1 SNREADY cycle before any new grant.
- Simultaneous events:
  - The owner dropping breq on the same cycle as hold expiry is a normal release (no mask).
  - New requests arriving during SNREADY are sampled only on the exit cycle.
- A grant is never given to a master whose breq is low. bgrant is never more than one-hot.

Decomposition:
- Package bus_arb_pkg:
  - state encoding localparams IDLE=2'd0, GRANT=2'd1, SNREADY=2'd2.
  - ARB_FIXED=0, ARB_RR=1.
- Sub-module arb_picker (combinational):
  - inputs: req, mask, rr_ptr, mode.
  - outputs: valid, index.
  - Instantiated once in SNREADY/IDLE arbitration; unit-testable standalone.
- Top holds the FSM, owner, rr_ptr, hold_cnt and preempt_mask registers.

Test Plan:
- Fixed mode, N=4: breq=4'b1010 from IDLE -> next cycle bgrant=4'b0010, msel=1. Drop breq[1] -> SNREADY, sready=3'b011 for 2 cycles (no grant), sready=3'b111 -> bgrant=4'b1000, msel=3.
- RR mode: breq=4'b1111 held, each owner drops breq for 1 cycle after 2 grant cycles, sready all high -> grant order 0,1,2,3,0.
- RR mode, MAX_HOLD=4: master 2 holds, master 0 requests -> after 4 GRANT cycles go to SNREADY. Next grant goes to master 0 even though breq[2] is still high.
- Fixed mode, MAX_HOLD=4: master 0 holds, master 3 requests -> preempt, master 3 granted once. After master 3 releases, master 0 is granted again.
- Async reset: assert rstn=0 mid-GRANT between clock edges -> bgrant=0, bus_busy=0, msel=0 without a clock edge. After release with breq=0 -> remains IDLE.
- No requests in SNREADY: owner releases, sready goes high, breq=0 -> IDLE, bus_busy=0, msel retains last owner.
